countdown_timer: RTL
====================

# countdown_timer

Countdown companion to the stopwatch on the same FPGA board: counts down instead of up. The user dials a preset of up to 99.9 s with the push-buttons, then starts, pauses or aborts the count. The block raises an alarm at 00.0. It shares the board's keys, seven-segment digits and tick generation style with the stopwatch, and drives HEX0..HEX2 plus one LED.

## Interface
- MIN_COUNT_IN_MS, 100, tick period in ms (resolution of the least-significant digit)
- FREQ_MHZ, 50, clk frequency in MHz
- DIV_FREQ (localparam) = FREQ_MHZ*1000*MIN_COUNT_IN_MS, clk cycles per tick
- clk  input  1  single clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- KEY1  input  1  raw button, active-low: start/pause/resume, reload in DONE
- KEY2  input  1  raw button, active-low: increment units-of-seconds digit
- KEY3  input  1  raw button, active-low: increment tens-of-seconds digit, abort in PAUSE
- HEX0  output  7  tenths digit, segments active-low
- HEX1  output  7  units digit
- HEX2  output  7  tens digit
- LEDR0  output  1  alarm, high in DONE
- running  output  1  high in RUN

## Operation
- Key conditioning: each KEY passes through a 2-flop synchroniser and a falling-edge detector, giving a one-cycle pulse. A held key gives exactly one pulse.
- Count value: three BCD digits, tens.units.tenths. preset register holds the same three digits. Reset value of both is 00.0.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- IDLE:
  - KEY2 increments the units digit, wrapping 9→0 with no carry.
  - KEY3 increments the tens digit, wrapping 9→0. The tenths digit stays 0.
  - KEY1 with value ≠ 00.0 captures preset := value and moves to RUN.
  - KEY1 with value = 00.0 is ignored.
- RUN:
  - Each tick decrements the value in BCD: a 0 digit becomes 9 and borrows from the next digit.
  - A tick at 00.1 gives 00.0 and moves to DONE in the same cycle.
  - KEY1 moves to PAUSE. KEY2 and KEY3 are ignored.
- PAUSE:
  - Value is frozen.
  - KEY1 moves to RUN.
  - KEY3 aborts: value := preset, move to IDLE.
  - KEY2 is ignored.
- DONE:
  - LEDR0 = 1.
  - KEY1 reloads value := preset and moves to IDLE.
  - KEY2 or KEY3 sets value := 00.0 and moves to IDLE. The press does not also increment.
- Simultaneous pulses in one cycle: KEY1 wins over KEY3, which wins over KEY2. Lower-priority pulses are dropped.
- Tick divider: a counter 0..DIV_FREQ-1 that pulses a one-cycle tick when it reaches DIV_FREQ-1. The counter is held at 0 whenever the state is not RUN.
- HEX digits come from the existing digit-to-segment decoder, applied to the value. Outputs are registered.

## Timing
- rst_n low forces immediately (asynchronously):
  - HEX0/1/2 = 7'b1000000 (digit 0)
  - LEDR0 = 0, running = 0
  - state IDLE, value and preset 00.0, divider 0, synchroniser flops 1
- Key latency: the key pulse is high in the 3rd clk cycle after the first posedge that samples KEY low. The state/value update lands on the next edge.
- HEX and LEDR0/running follow state/value with 1 cycle of latency.
- First decrement comes DIV_FREQ cycles after the state becomes RUN, and likewise after resume. The partial tick at pause is discarded.
- Reset deasserted mid-count: the block restarts in IDLE at 00.0 and does not resume.

## Configuration
- COUNTDOWN_BLINK_EN defined:
  - In DONE the divider keeps running.
  - HEX0..HEX2 alternate between 00.0 and blank (7'b1111111) every 5 ticks, starting with 00.0.
  - LEDR0 blinks in phase with the display.
- COUNTDOWN_BLINK_EN undefined:
  - DONE shows a steady 00.0 with LEDR0 steady high.
  - The divider is held at 0.

## Structure
- Shared package holds:
  - the segment constants (DISPLAY_0 = 7'b1000000, DISPLAY_BLANK = 7'b1111111)
  - the BCD digit width (4)
  - the FSM state encoding (IDLE/RUN/PAUSE/DONE)
- Sub-module key_edge: 2-flop synchroniser plus falling-edge pulse, instantiated three times.
- Reuses the existing digit-to-segment decoder, instantiated three times.

## Test plan
Benches use FREQ_MHZ=1 and MIN_COUNT_IN_MS=1, so DIV_FREQ=1000.
- Set-and-run: KEY2 ×1, then KEY1.
  - running=1.
  - 10 ticks later (10000 cycles): HEX = 00.0 and LEDR0=1 one cycle after the transition to DONE.
- Borrow: KEY3 ×1 to set 10.0, then KEY1. After 1000 cycles HEX shows 09.9.
- Pause/resume: preset 01.0, run 3 ticks, then KEY1.
  - Display holds 00.7 for 5000 cycles.
  - KEY1 again: DONE after a further 7000 cycles.
- IDLE edge cases:
  - KEY1 at 00.0 leaves running=0.
  - KEY3 ×10 returns tens to 0.
  - KEY1 and KEY2 pulsed in the same cycle: the state goes to RUN and the units digit is unchanged.
- Reload and abort:
  - In DONE, KEY1 gives IDLE with HEX 01.0.
  - In PAUSE, KEY3 gives IDLE with the preset shown.
- Async reset: drop rst_n mid-RUN between clk edges.
  - HEX = 7'b1000000 ×3, LEDR0=0 and running=0 before the next posedge.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: segment patterns, BCD digit type,
// FSM state encoding and BCD helpers.
package countdown_timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] DISPLAY_0     = 7'b1000000;
  localparam logic [6:0] DISPLAY_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
    logic [DIGIT_W-1:0] tenths;
  } bcd_t;

  localparam bcd_t BCD_ZERO       = '0;
  localparam bcd_t BCD_POINT_ONE  = 12'h001;

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? '0 : d + 1'b1;
  endfunction

  // Decrement of the three-digit value; a zero digit becomes 9 and borrows.
  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.tenths != '0) begin
      r.tenths = v.tenths - 1'b1;
    end else begin
      r.tenths = 4'd9;
      if (v.units != '0) begin
        r.units = v.units - 1'b1;
      end else begin
        r.units = 4'd9;
        r.tens  = v.tens - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Push-button conditioning: 2-flop synchroniser followed by a registered
// falling-edge detector producing one pulse per press.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= prev & ~sync2;
    end
  end

endmodule

// File: rtl/seg_decoder.sv
// Digit-to-segment decoder for the board's active-low seven-segment displays.
module seg_decoder
  import countdown_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = DISPLAY_0;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = DISPLAY_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer with 99.9 s preset, pause/resume/abort and alarm at 00.0.
// Optional COUNTDOWN_BLINK_EN makes the display and alarm LED blink in DONE.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int MIN_COUNT_IN_MS = 100,
  parameter int FREQ_MHZ        = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic       KEY3,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       LEDR0,
  output logic       running
);

  localparam int DIV_FREQ = FREQ_MHZ * 1000 * MIN_COUNT_IN_MS;
  localparam int CNT_W    = (DIV_FREQ > 1) ? $clog2(DIV_FREQ) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_FREQ - 1);

  logic       key1_p, key2_p, key3_p;
  state_t     state;
  bcd_t       value, preset;
  logic [CNT_W-1:0] div_cnt;
  logic       div_en, tick, blank;
  logic [6:0] seg0, seg1, seg2;

  key_edge u_key1 (.clk(clk), .rst_n(rst_n), .key(KEY1), .pulse(key1_p));
  key_edge u_key2 (.clk(clk), .rst_n(rst_n), .key(KEY2), .pulse(key2_p));
  key_edge u_key3 (.clk(clk), .rst_n(rst_n), .key(KEY3), .pulse(key3_p));

  always_comb begin
    div_en = (state == RUN);
`ifdef COUNTDOWN_BLINK_EN
    if (state == DONE) div_en = 1'b1;
`endif
    tick = div_en && (div_cnt == DIV_LAST);
  end

  // Held at zero outside counting states so every (re)start gets a full tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       div_cnt <= '0;
    else if (!div_en) div_cnt <= '0;
    else if (tick)    div_cnt <= '0;
    else              div_cnt <= div_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      value  <= BCD_ZERO;
      preset <= BCD_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (key1_p) begin
            if (value != BCD_ZERO) begin
              preset <= value;
              state  <= RUN;
            end
          end else if (key3_p) begin
            value.tens <= digit_inc(value.tens);
          end else if (key2_p) begin
            value.units <= digit_inc(value.units);
          end
        end
        RUN: begin
          if (key1_p) begin
            state <= PAUSE;
          end else if (tick) begin
            value <= bcd_dec(value);
            if (value == BCD_POINT_ONE) state <= DONE;
          end
        end
        PAUSE: begin
          if (key1_p) begin
            state <= RUN;
          end else if (key3_p) begin
            value <= preset;
            state <= IDLE;
          end
        end
        DONE: begin
          if (key1_p) begin
            value <= preset;
            state <= IDLE;
          end else if (key2_p || key3_p) begin
            value <= BCD_ZERO;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic [2:0] blink_cnt;

  // Display phase flips every fifth tick while the alarm is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (state != DONE) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == 3'd4) begin
        blink_cnt <= '0;
        blank     <= ~blank;
      end else begin
        blink_cnt <= blink_cnt + 3'd1;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg_decoder u_dec0 (.digit(value.tenths), .seg(seg0));
  seg_decoder u_dec1 (.digit(value.units),  .seg(seg1));
  seg_decoder u_dec2 (.digit(value.tens),   .seg(seg2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HEX0    <= DISPLAY_0;
      HEX1    <= DISPLAY_0;
      HEX2    <= DISPLAY_0;
      LEDR0   <= 1'b0;
      running <= 1'b0;
    end else begin
      HEX0    <= blank ? DISPLAY_BLANK : seg0;
      HEX1    <= blank ? DISPLAY_BLANK : seg1;
      HEX2    <= blank ? DISPLAY_BLANK : seg2;
      LEDR0   <= (state == DONE) && !blank;
      running <= (state == RUN);
    end
  end

endmodule
